// File: rtl/iob_split_reg.sv
// iob_split_reg: registered native-bus splitter, one master routed to N_SLAVES slaves by an address bit field
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   m_req    in   master request  {valid, addr, wdata, wstrb}
//   m_resp   out  master response {rdata, ready}
//   s_req    out  slave requests,  slave k at [k*REQ_W +: REQ_W]
//   s_resp   in   slave responses, slave k at [k*RESP_W +: RESP_W]
//   err      out  one-cycle pulse alongside the master ready of an error response
//   err_sel  out  select value of the most recent error
//
// Optional feature macro: SPLIT_TIMEOUT_EN (abandon a slave that stays not-ready for TIMEOUT cycles).
module iob_split_reg #(
    parameter int N_SLAVES = 2,
    parameter int P_SLAVES = 31,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF,
    localparam int SEL_W = $clog2(N_SLAVES),
    localparam int STRB_W = DATA_W / 8,
    localparam int REQ_W = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W = DATA_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err,
    output logic [SEL_W-1:0]           err_sel
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state;
    logic m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [SEL_W-1:0] m_sel;
    logic [SEL_W-1:0] sel_q;
    logic m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic s_rdy;
    logic [DATA_W-1:0] s_rdata;
`ifdef SPLIT_TIMEOUT_EN
    logic [15:0] cnt;
`endif
    assign m_valid = m_req[REQ_W-1];
    assign m_addr = m_req[REQ_W-2 -: ADDR_W];
    assign m_wdata = m_req[STRB_W +: DATA_W];
    assign m_wstrb = m_req[STRB_W-1:0];
    assign m_sel = m_addr[P_SLAVES -: SEL_W];
    assign m_resp = {m_rdata, m_ready};
    // Response of the latched slave only; other slaves are never looked at.
    always_comb begin
        s_rdy = 1'b0;
        s_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++)
            if (SEL_W'(k) == sel_q) {s_rdata, s_rdy} = s_resp[k*RESP_W +: RESP_W];
    end
    // s_req doubles as the request latch: only the selected slice is loaded,
    // every other slice stays all-zero, and the whole vector clears on leaving REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            s_req <= '0;
            sel_q <= '0;
            m_ready <= 1'b0;
            m_rdata <= '0;
            err <= 1'b0;
            err_sel <= '0;
`ifdef SPLIT_TIMEOUT_EN
            cnt <= '0;
`endif
        end else begin
            m_ready <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (m_valid) begin
                    sel_q <= m_sel;
                    if (int'(m_sel) < N_SLAVES) begin
                        for (int k = 0; k < N_SLAVES; k++)
                            if (SEL_W'(k) == m_sel) s_req[k*REQ_W +: REQ_W] <= {1'b1, m_addr, m_wdata, m_wstrb};
`ifdef SPLIT_TIMEOUT_EN
                        cnt <= '0;
`endif
                        state <= REQ;
                    end else begin
                        m_ready <= 1'b1;
                        m_rdata <= ERR_DATA;
                        err <= 1'b1;
                        err_sel <= m_sel;
                        state <= RESP;
                    end
                end
                REQ: if (s_rdy) begin
                    s_req <= '0;
                    m_ready <= 1'b1;
                    m_rdata <= s_rdata;
                    state <= RESP;
                end
`ifdef SPLIT_TIMEOUT_EN
                // The TIMEOUT-th REQ cycle without ready expires; a ready in that cycle wins above.
                else if (cnt == 16'(TIMEOUT - 1)) begin
                    s_req <= '0;
                    m_ready <= 1'b1;
                    m_rdata <= ERR_DATA;
                    err <= 1'b1;
                    err_sel <= sel_q;
                    state <= RESP;
                end else cnt <= cnt + 16'd1;
`endif
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_split_reg.sv
// tb_iob_split_reg: directed self-checking bench for iob_split_reg with N_SLAVES=3, TIMEOUT=8
module tb_iob_split_reg;
    localparam int RW = 69;
    localparam int PW = 33;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [RW-1:0] m_req = '0;
    logic [PW-1:0] m_resp;
    logic [3*RW-1:0] s_req;
    logic [3*PW-1:0] s_resp = '0;
    logic err;
    logic [1:0] err_sel;
    int n_tests = 0;
    int n_fail = 0;

    iob_split_reg #(.N_SLAVES(3), .P_SLAVES(31), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .err(err), .err_sel(err_sel));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic sv(int k);
        return s_req[k*RW+68];
    endfunction
    function automatic logic [31:0] sa(int k);
        return s_req[k*RW+36 +: 32];
    endfunction
    function automatic logic [31:0] sw(int k);
        return s_req[k*RW+4 +: 32];
    endfunction
    function automatic logic [3:0] ss(int k);
        return s_req[k*RW +: 4];
    endfunction
    function automatic logic [2:0] svs();
        return {sv(2), sv(1), sv(0)};
    endfunction

    task automatic set_resp(int k, logic rdy, logic [31:0] d);
        s_resp[k*PW +: PW] = {d, rdy};
    endtask

    task automatic test_reset;
        n_tests++; if (svs() !== 3'b000) begin n_fail++; $display("FAIL reset_svalid: got %b expected 000", svs()); end
        n_tests++; if (m_resp[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mready: got %b expected 0", m_resp[0]); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_tests++; if (err_sel !== 2'd0) begin n_fail++; $display("FAIL reset_err_sel: got %0d expected 0", err_sel); end
    endtask

    task automatic test_write;
        m_req = {1'b1, 32'h4000_0010, 32'hCAFE_0001, 4'hF};
        tick;
        m_req = '0;
        n_tests++; if (svs() !== 3'b010) begin n_fail++; $display("FAIL write_svalid: got %b expected 010", svs()); end
        n_tests++; if (sa(1) !== 32'h4000_0010) begin n_fail++; $display("FAIL write_addr: got %h expected 40000010", sa(1)); end
        n_tests++; if (sw(1) !== 32'hCAFE_0001) begin n_fail++; $display("FAIL write_wdata: got %h expected cafe0001", sw(1)); end
        n_tests++; if (ss(1) !== 4'hF) begin n_fail++; $display("FAIL write_wstrb: got %h expected f", ss(1)); end
        n_tests++; if ({sa(0), sw(0), sa(2), sw(2)} !== 128'd0) begin n_fail++; $display("FAIL write_others_zero: got %h %h expected 0", sa(0), sa(2)); end
        n_tests++; if (m_resp[0] !== 1'b0) begin n_fail++; $display("FAIL write_early_ready: got %b expected 0", m_resp[0]); end
        set_resp(1, 1'b1, 32'h1111_2222);
        tick;
        set_resp(1, 1'b0, 32'h0);
        n_tests++; if (m_resp !== {32'h1111_2222, 1'b1}) begin n_fail++; $display("FAIL write_resp: got %h expected %h", m_resp, {32'h1111_2222, 1'b1}); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b expected 0", err); end
        n_tests++; if (svs() !== 3'b000) begin n_fail++; $display("FAIL write_svalid_after: got %b expected 000", svs()); end
        tick;
        n_tests++; if (m_resp[0] !== 1'b0) begin n_fail++; $display("FAIL write_ready_pulse: got %b expected 0", m_resp[0]); end
    endtask

    task automatic test_read_wait;
        set_resp(0, 1'b1, 32'h0BAD_0BAD);
        m_req = {1'b1, 32'h8000_0000, 32'h0, 4'h0};
        tick;
        m_req = '0;
        for (int i = 1; i <= 5; i++) begin
            n_tests++; if (svs() !== 3'b100) begin n_fail++; $display("FAIL read_svalid_c%0d: got %b expected 100", i, svs()); end
            n_tests++; if (m_resp[0] !== 1'b0) begin n_fail++; $display("FAIL read_wait_ready_c%0d: got %b expected 0", i, m_resp[0]); end
            tick;
        end
        n_tests++; if (svs() !== 3'b100) begin n_fail++; $display("FAIL read_svalid_c6: got %b expected 100", svs()); end
        set_resp(2, 1'b1, 32'h1234_5678);
        tick;
        set_resp(2, 1'b0, 32'h0);
        set_resp(0, 1'b0, 32'h0);
        n_tests++; if (m_resp !== {32'h1234_5678, 1'b1}) begin n_fail++; $display("FAIL read_resp: got %h expected %h", m_resp, {32'h1234_5678, 1'b1}); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b expected 0", err); end
        tick;
    endtask

    task automatic test_unmapped;
        m_req = {1'b1, 32'hC000_0000, 32'h0, 4'h0};
        tick;
        m_req = '0;
        n_tests++; if (m_resp !== {32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL unmapped_resp: got %h expected %h", m_resp, {32'hDEAD_BEEF, 1'b1}); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err: got %b expected 1", err); end
        n_tests++; if (err_sel !== 2'd3) begin n_fail++; $display("FAIL unmapped_err_sel: got %0d expected 3", err_sel); end
        n_tests++; if (svs() !== 3'b000) begin n_fail++; $display("FAIL unmapped_svalid: got %b expected 000", svs()); end
        tick;
        n_tests++; if ({m_resp[0], err} !== 2'b00) begin n_fail++; $display("FAIL unmapped_pulse: got %b expected 00", {m_resp[0], err}); end
        n_tests++; if (err_sel !== 2'd3) begin n_fail++; $display("FAIL unmapped_err_sel_hold: got %0d expected 3", err_sel); end
    endtask

    task automatic test_timeout;
        m_req = {1'b1, 32'h0000_0100, 32'h5, 4'h1};
        tick;
        m_req = '0;
`ifdef SPLIT_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if ({svs(), m_resp[0]} !== 4'b0010) begin n_fail++; $display("FAIL timeout_wait_c%0d: got %b expected 0010", i, {svs(), m_resp[0]}); end
            tick;
        end
        n_tests++; if (svs() !== 3'b000) begin n_fail++; $display("FAIL timeout_svalid: got %b expected 000", svs()); end
        n_tests++; if (m_resp !== {32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL timeout_resp: got %h expected %h", m_resp, {32'hDEAD_BEEF, 1'b1}); end
        n_tests++; if ({err, err_sel} !== 3'b100) begin n_fail++; $display("FAIL timeout_err: got %b expected 100", {err, err_sel}); end
        tick;
`else
        for (int i = 1; i <= 100; i++) begin
            n_tests++; if ({svs(), m_resp[0]} !== 4'b0010) begin n_fail++; $display("FAIL hang_wait_c%0d: got %b expected 0010", i, {svs(), m_resp[0]}); end
            tick;
        end
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick;
`endif
    endtask

    task automatic test_reset_mid;
        m_req = {1'b1, 32'h8000_0040, 32'h77, 4'h3};
        tick;
        m_req = '0;
        n_tests++; if (svs() !== 3'b100) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 100", svs()); end
        rst = 1'b0;
        #1;
        n_tests++; if ({svs(), m_resp[0], err} !== 5'b00000) begin n_fail++; $display("FAIL rstmid_async: got %b expected 00000", {svs(), m_resp[0], err}); end
        #1;
        rst = 1'b1;
        tick;
        n_tests++; if ({svs(), m_resp[0]} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_abandon: got %b expected 0000", {svs(), m_resp[0]}); end
        set_resp(1, 1'b1, 32'hFEED_0042);
        m_req = {1'b1, 32'h4000_0004, 32'h9, 4'h2};
        tick;
        m_req = '0;
        n_tests++; if (svs() !== 3'b010) begin n_fail++; $display("FAIL rstmid_new_svalid: got %b expected 010", svs()); end
        tick;
        set_resp(1, 1'b0, 32'h0);
        n_tests++; if (m_resp !== {32'hFEED_0042, 1'b1}) begin n_fail++; $display("FAIL rstmid_new_resp: got %h expected %h", m_resp, {32'hFEED_0042, 1'b1}); end
        tick;
    endtask

    task automatic test_back_to_back;
        set_resp(1, 1'b1, 32'hAAAA_0001);
        set_resp(2, 1'b1, 32'hBBBB_0002);
        m_req = {1'b1, 32'h4000_0000, 32'h0, 4'h0};
        tick;
        n_tests++; if (svs() !== 3'b010) begin n_fail++; $display("FAIL b2b_first_svalid: got %b expected 010", svs()); end
        tick;
        n_tests++; if (m_resp !== {32'hAAAA_0001, 1'b1}) begin n_fail++; $display("FAIL b2b_first_resp: got %h expected %h", m_resp, {32'hAAAA_0001, 1'b1}); end
        m_req = {1'b1, 32'h8000_0000, 32'h0, 4'h0};
        tick;
        n_tests++; if ({svs(), m_resp[0]} !== 4'b0000) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 0000", {svs(), m_resp[0]}); end
        tick;
        m_req = '0;
        n_tests++; if (svs() !== 3'b100) begin n_fail++; $display("FAIL b2b_second_svalid: got %b expected 100", svs()); end
        n_tests++; if (sa(2) !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 80000000", sa(2)); end
        tick;
        n_tests++; if (m_resp !== {32'hBBBB_0002, 1'b1}) begin n_fail++; $display("FAIL b2b_second_resp: got %h expected %h", m_resp, {32'hBBBB_0002, 1'b1}); end
        tick;
        n_tests++; if ({svs(), m_resp[0]} !== 4'b0000) begin n_fail++; $display("FAIL b2b_done: got %b expected 0000", {svs(), m_resp[0]}); end
        set_resp(1, 1'b0, 32'h0);
        set_resp(2, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b1;
        tick;
        test_write;
        test_read_wait;
        test_unmapped;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
